regfile_write_arbiter: RTL and testbench

- Shares the register file's single write port (regwrite / write_register / write_data) between two writeback requesters: memory-load writeback (mem) and ALU writeback (alu).
- Uses valid/ready handshakes and grants at most one write per cycle.
- Mem has fixed priority, with an anti-starvation counter that promotes alu.
- Sits between the writeback stage and the register file; the register file samples the registered write outputs on the next posedge clk.

---
 rtl/regfile_write_arbiter.sv | 117 +++++++++++
 tb/tb_regfile_write_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// Two-requester write-port arbiter for the register file: mem has fixed priority,
// alu is promoted after STARVE_LIMIT starved cycles. Optional RF_WRITE_COUNT_EN adds commit_count.
module regfile_write_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [4:0]  mem_reg,
    input  logic [31:0] mem_data,
    input  logic        alu_valid,
    output logic        alu_ready,
    input  logic [4:0]  alu_reg,
    input  logic [31:0] alu_data,
    output logic        regwrite,
    output logic [4:0]  write_register,
    output logic [31:0] write_data,
`ifdef RF_WRITE_COUNT_EN
    output logic [31:0] commit_count,
`endif
    output logic        alu_promoted
);

    typedef enum logic {PRIO_MEM, PRIO_ALU} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             mem_xfer, alu_xfer, alu_wait;

    always_comb begin
        mem_ready = 1'b0;
        alu_ready = 1'b0;
        if (!rst && !stall) begin
            case (state)
                PRIO_MEM: begin
                    mem_ready = mem_valid;
                    alu_ready = alu_valid & ~mem_valid;
                end
                default: begin
                    alu_ready = alu_valid;
                    mem_ready = mem_valid & ~alu_valid;
                end
            endcase
        end
    end

    assign mem_xfer     = mem_valid & mem_ready;
    assign alu_xfer     = alu_valid & alu_ready;
    assign alu_wait     = alu_valid & ~alu_ready;
    assign alu_promoted = (state == PRIO_ALU);

    // Promotion happens on the same edge the count would reach the limit,
    // so the counter is cleared as PRIO_ALU is entered.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            PRIO_MEM: begin
                if (alu_wait) begin
                    if (cnt >= CNT_W'(STARVE_LIMIT - 1)) begin
                        state_nxt = PRIO_ALU;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end else begin
                    cnt_nxt = '0;
                end
            end
            default: begin
                cnt_nxt = '0;
                if (alu_xfer || !alu_valid) state_nxt = PRIO_MEM;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= PRIO_MEM;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regwrite       <= 1'b0;
            write_register <= '0;
            write_data     <= '0;
        end else if (mem_xfer) begin
            regwrite       <= (mem_reg != 5'd0);
            write_register <= mem_reg;
            write_data     <= mem_data;
        end else if (alu_xfer) begin
            regwrite       <= (alu_reg != 5'd0);
            write_register <= alu_reg;
            write_data     <= alu_data;
        end else begin
            regwrite <= 1'b0;
        end
    end

`ifdef RF_WRITE_COUNT_EN
    always_ff @(posedge clk) begin
        if (rst)
            commit_count <= '0;
        else if ((mem_xfer && mem_reg != 5'd0) || (alu_xfer && alu_reg != 5'd0))
            commit_count <= commit_count + 32'd1;
    end
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with a per-cycle reference model
// plus literal expectations for each scenario.
module tb_regfile_write_arbiter;
    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst, stall;
    logic        mem_valid, alu_valid;
    logic        mem_ready, alu_ready;
    logic [4:0]  mem_reg, alu_reg;
    logic [31:0] mem_data, alu_data;
    logic        regwrite, alu_promoted;
    logic [4:0]  write_register;
    logic [31:0] write_data;
`ifdef RF_WRITE_COUNT_EN
    logic [31:0] commit_count;
`endif

    int checks = 0;
    int errors = 0;

    regfile_write_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_reg(mem_reg), .mem_data(mem_data),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_reg(alu_reg), .alu_data(alu_data),
        .regwrite(regwrite), .write_register(write_register), .write_data(write_data),
`ifdef RF_WRITE_COUNT_EN
        .commit_count(commit_count),
`endif
        .alu_promoted(alu_promoted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: "promoted" flag, count of consecutive starved alu cycles,
    // and the last accepted write.
    bit          m_promo = 0;
    int          m_wait  = 0;
    bit          m_we    = 0;
    logic [4:0]  m_reg   = '0;
    logic [31:0] m_data  = '0;
    logic [31:0] m_cc    = '0;
    bit          armed   = 0;

    always @(negedge clk) begin
        bit gm, ga;
        if (armed) begin
            chk("m_regwrite", {31'd0, regwrite}, {31'd0, m_we});
            chk("m_wreg", {27'd0, write_register}, {27'd0, m_reg});
            chk("m_wdata", write_data, m_data);
            chk("m_promoted", {31'd0, alu_promoted}, {31'd0, m_promo});
`ifdef RF_WRITE_COUNT_EN
            chk("m_commit_count", commit_count, m_cc);
`endif
        end
        gm = 0; ga = 0;
        if (!rst && !stall) begin
            if (m_promo) begin ga = alu_valid; gm = mem_valid && !alu_valid; end
            else         begin gm = mem_valid; ga = alu_valid && !mem_valid; end
        end
        chk("m_mem_ready", {31'd0, mem_ready}, {31'd0, gm});
        chk("m_alu_ready", {31'd0, alu_ready}, {31'd0, ga});
        if (rst) begin
            m_promo = 0; m_wait = 0; m_we = 0; m_reg = '0; m_data = '0; m_cc = '0;
            armed = 1;
        end else begin
            if (gm)      begin m_we = (mem_reg != 0); m_reg = mem_reg; m_data = mem_data; end
            else if (ga) begin m_we = (alu_reg != 0); m_reg = alu_reg; m_data = alu_data; end
            else         m_we = 0;
            if (m_we) m_cc = m_cc + 1;
            if (!m_promo) begin
                m_wait = (alu_valid && !ga) ? m_wait + 1 : 0;
                if (m_wait >= LIMIT) begin m_promo = 1; m_wait = 0; end
            end else if (ga || !alu_valid) begin
                m_promo = 0;
            end
        end
    end

    // Inputs change 1 time unit after posedge; checks happen at the following negedge.
    task automatic cyc();
        @(posedge clk); #1;
    endtask
    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        rst = 1; stall = 0;
        mem_valid = 1; alu_valid = 1;
        mem_reg = 5'd1; alu_reg = 5'd2; mem_data = 32'h1; alu_data = 32'h2;
        #1;
        // Reset with both requesting
        for (int i = 0; i < 2; i++) begin
            mid();
            chk("rst_mem_ready", {31'd0, mem_ready}, 32'd0);
            chk("rst_alu_ready", {31'd0, alu_ready}, 32'd0);
            cyc();
        end
        rst = 0; mem_valid = 0; alu_valid = 0;
        mid();
        chk("rst_regwrite", {31'd0, regwrite}, 32'd0);
        chk("rst_wreg", {27'd0, write_register}, 32'd0);
        chk("rst_wdata", write_data, 32'd0);
        chk("rst_promoted", {31'd0, alu_promoted}, 32'd0);

        // Single alu write
        cyc();
        alu_valid = 1; alu_reg = 5'd5; alu_data = 32'hDEADBEEF;
        mid();
        chk("single_alu_ready", {31'd0, alu_ready}, 32'd1);
        cyc();
        alu_valid = 0;
        mid();
        chk("single_regwrite", {31'd0, regwrite}, 32'd1);
        chk("single_wreg", {27'd0, write_register}, 32'd5);
        chk("single_wdata", write_data, 32'hDEADBEEF);
        cyc();
        mid();
        chk("single_regwrite_off", {31'd0, regwrite}, 32'd0);

        // Contention: period LIMIT+1 with one alu slot
        cyc();
        mem_valid = 1; alu_valid = 1;
        mem_reg = 5'd3; alu_reg = 5'd7; mem_data = 32'hAAAA0003; alu_data = 32'hBBBB0007;
        for (int c = 0; c < 10; c++) begin
            mid();
            chk("cont_mem_ready", {31'd0, mem_ready}, (c % 5 == 4) ? 32'd0 : 32'd1);
            chk("cont_alu_ready", {31'd0, alu_ready}, (c % 5 == 4) ? 32'd1 : 32'd0);
            chk("cont_promoted", {31'd0, alu_promoted}, (c % 5 == 4) ? 32'd1 : 32'd0);
            cyc();
        end
        mem_valid = 0; alu_valid = 0;
        mid();
        chk("cont_last_wreg", {27'd0, write_register}, 32'd7);

        // Write to $0: accepted but not committed
        cyc();
        mem_valid = 1; mem_reg = 5'd0; mem_data = 32'h1234;
        mid();
        chk("zero_mem_ready", {31'd0, mem_ready}, 32'd1);
        cyc();
        mem_valid = 0;
        mid();
        chk("zero_regwrite", {31'd0, regwrite}, 32'd0);
        chk("zero_wreg", {27'd0, write_register}, 32'd0);
        chk("zero_wdata", write_data, 32'h1234);

        // Stall for 3 cycles stays under the promotion threshold
        cyc();
        stall = 1; alu_valid = 1; alu_reg = 5'd9; alu_data = 32'h55;
        for (int i = 0; i < 3; i++) begin
            mid();
            chk("stall_alu_ready", {31'd0, alu_ready}, 32'd0);
            chk("stall_regwrite", {31'd0, regwrite}, 32'd0);
            chk("stall_promoted", {31'd0, alu_promoted}, 32'd0);
            cyc();
        end
        stall = 0;
        mid();
        chk("stall_rel_alu_ready", {31'd0, alu_ready}, 32'd1);
        chk("stall_rel_promoted", {31'd0, alu_promoted}, 32'd0);
        cyc();
        alu_valid = 0;
        mid();
        chk("stall_rel_regwrite", {31'd0, regwrite}, 32'd1);
        chk("stall_rel_wreg", {27'd0, write_register}, 32'd9);

        // Promotion, stall while promoted, then reset mid-contention
        cyc();
        mem_valid = 1; alu_valid = 1; mem_reg = 5'd3; alu_reg = 5'd7;
        for (int c = 0; c < 4; c++) begin cyc(); end
        stall = 1;
        for (int i = 0; i < 2; i++) begin
            mid();
            chk("pstall_promoted", {31'd0, alu_promoted}, 32'd1);
            chk("pstall_alu_ready", {31'd0, alu_ready}, 32'd0);
            cyc();
        end
        rst = 1;
        cyc();
        rst = 0; stall = 0;
        for (int c = 0; c < 5; c++) begin
            mid();
            if (c == 0) chk("prst_regwrite", {31'd0, regwrite}, 32'd0);
            chk("prst_promoted", {31'd0, alu_promoted}, (c == 4) ? 32'd1 : 32'd0);
            chk("prst_mem_ready", {31'd0, mem_ready}, (c == 4) ? 32'd0 : 32'd1);
            cyc();
        end

        // Promoted alu withdraws its request
        for (int c = 0; c < 4; c++) begin cyc(); end
        alu_valid = 0;
        mid();
        chk("wd_promoted_before", {31'd0, alu_promoted}, 32'd1);
        chk("wd_mem_ready", {31'd0, mem_ready}, 32'd1);
        cyc();
        mem_valid = 0;
        mid();
        chk("wd_promoted_after", {31'd0, alu_promoted}, 32'd0);

        // Same destination register: later-granted alu write lands last
        cyc();
        mem_valid = 1; alu_valid = 1; mem_reg = 5'd4; alu_reg = 5'd4;
        mem_data = 32'h0000_1111; alu_data = 32'h0000_2222;
        mid();
        chk("same_mem_first", {31'd0, mem_ready}, 32'd1);
        cyc();
        mem_valid = 0;
        mid();
        chk("same_alu_second", {31'd0, alu_ready}, 32'd1);
        chk("same_wdata_mem", write_data, 32'h0000_1111);
        cyc();
        alu_valid = 0;
        mid();
        chk("same_wdata_alu", write_data, 32'h0000_2222);
        chk("same_wreg", {27'd0, write_register}, 32'd4);
        cyc();
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
